// File: rtl/tetron_shaper.sv
// Tetromino block-offset generator: latches a piece, proposes rotations,
// and commits or reverts them, with a one-cycle offset lookup stage.
module tetron_shaper #(
    parameter int unsigned COORD_W     = 5,
    parameter int unsigned I_FIRST_ROW = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               active,
    input  logic               load,
    input  logic [2:0]         shape,
    input  logic               rot_cw,
    input  logic               rot_ccw,
    input  logic               accept,
    input  logic               reject,
    output logic               busy,
    output logic               pending,
    output logic               out_valid,
    output logic [1:0]         rotation,
    output logic [2:0]         cur_shape,
    output logic [COORD_W-1:0] blk1_voffset,
    output logic [COORD_W-1:0] blk2_voffset,
    output logic [COORD_W-1:0] blk3_voffset,
    output logic [COORD_W-1:0] blk4_voffset,
    output logic [COORD_W-1:0] blk1_hoffset,
    output logic [COORD_W-1:0] blk2_hoffset,
    output logic [COORD_W-1:0] blk3_hoffset,
    output logic [COORD_W-1:0] blk4_hoffset
);

    typedef enum logic [1:0] {IDLE, LOOKUP, STABLE, PENDING} state_t;

    state_t     state;
    logic       ret_pending;
    logic [1:0] prev_rot;
    logic       load_ok_c;
    logic [1:0] lv [4];
    logic [1:0] lh [4];
    logic [1:0] smax;
    logic [1:0] tmp;

    assign load_ok_c = load && (shape != 3'd7);

    // Rotation-0 table for the latched piece, then up to three clockwise steps
    always_comb begin
        smax = (cur_shape == 3'd0) ? 2'd3 : 2'd2;
        tmp  = '0;
        for (int i = 0; i < 4; i++) begin
            lv[i] = '0;
            lh[i] = '0;
        end
        case (cur_shape)
            3'd0: begin
                for (int i = 0; i < 4; i++) begin
                    lv[i] = 2'(I_FIRST_ROW);
                    lh[i] = 2'(i);
                end
            end
            3'd1: begin lv = '{2'd0, 2'd1, 2'd0, 2'd1}; lh = '{2'd0, 2'd1, 2'd1, 2'd0}; end
            3'd2: begin lv = '{2'd0, 2'd1, 2'd1, 2'd1}; lh = '{2'd1, 2'd0, 2'd1, 2'd2}; end
            3'd3: begin lv = '{2'd0, 2'd0, 2'd1, 2'd1}; lh = '{2'd1, 2'd2, 2'd0, 2'd1}; end
            3'd4: begin lv = '{2'd0, 2'd0, 2'd1, 2'd1}; lh = '{2'd0, 2'd1, 2'd1, 2'd2}; end
            3'd5: begin lv = '{2'd0, 2'd1, 2'd1, 2'd1}; lh = '{2'd0, 2'd0, 2'd1, 2'd2}; end
            3'd6: begin lv = '{2'd0, 2'd1, 2'd1, 2'd1}; lh = '{2'd2, 2'd0, 2'd1, 2'd2}; end
            default: ;
        endcase
        // The O piece is rotation-invariant; its table is never rotated
        if (cur_shape != 3'd1) begin
            for (int s = 0; s < 3; s++) begin
                if (2'(s) < rotation) begin
                    for (int b = 0; b < 4; b++) begin
                        tmp   = lv[b];
                        lv[b] = lh[b];
                        lh[b] = smax - tmp;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            state        <= IDLE;
            ret_pending  <= 1'b0;
            prev_rot     <= '0;
            rotation     <= '0;
            cur_shape    <= '0;
            busy         <= 1'b0;
            pending      <= 1'b0;
            out_valid    <= 1'b0;
            blk1_voffset <= '0;
            blk2_voffset <= '0;
            blk3_voffset <= '0;
            blk4_voffset <= '0;
            blk1_hoffset <= '0;
            blk2_hoffset <= '0;
            blk3_hoffset <= '0;
            blk4_hoffset <= '0;
        end else begin
            case (state)
                IDLE, STABLE, PENDING: begin
                    // A load (even an illegal one) pre-empts every other command
                    if (load) begin
                        if (load_ok_c) begin
                            cur_shape   <= shape;
                            rotation    <= '0;
                            ret_pending <= 1'b0;
                            state       <= LOOKUP;
                            busy        <= 1'b1;
                            pending     <= 1'b0;
                            out_valid   <= 1'b0;
                        end
                    end else if (state == STABLE && (rot_cw ^ rot_ccw)) begin
                        prev_rot    <= rotation;
                        rotation    <= rot_cw ? rotation + 2'd1 : rotation - 2'd1;
                        ret_pending <= 1'b1;
                        state       <= LOOKUP;
                        busy        <= 1'b1;
                        out_valid   <= 1'b0;
                    end else if (state == PENDING && reject) begin
                        rotation    <= prev_rot;
                        ret_pending <= 1'b0;
                        state       <= LOOKUP;
                        busy        <= 1'b1;
                        pending     <= 1'b0;
                        out_valid   <= 1'b0;
                    end else if (state == PENDING && accept) begin
                        state   <= STABLE;
                        pending <= 1'b0;
                    end
                end
                LOOKUP: begin
                    blk1_voffset <= COORD_W'(lv[0]);
                    blk2_voffset <= COORD_W'(lv[1]);
                    blk3_voffset <= COORD_W'(lv[2]);
                    blk4_voffset <= COORD_W'(lv[3]);
                    blk1_hoffset <= COORD_W'(lh[0]);
                    blk2_hoffset <= COORD_W'(lh[1]);
                    blk3_hoffset <= COORD_W'(lh[2]);
                    blk4_hoffset <= COORD_W'(lh[3]);
                    state        <= ret_pending ? PENDING : STABLE;
                    busy         <= 1'b0;
                    pending      <= ret_pending;
                    out_valid    <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tetron_shaper.md
TETRON_SHAPER -- requirements
Module: tetron_shaper

Interface
REQ-001 Parameter COORD_W, default 5: width of each offset output; legal values are 2 or greater.
REQ-002 Parameter I_FIRST_ROW, default 1: row (0..3) occupied by the I piece at rotation 0.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 active  input  1  enable; when low, behaves as reset on the next edge.
REQ-006 load  input  1  pulse: new piece; samples shape.
REQ-007 shape  input  3  piece code: 0=I, 1=O, 2=T, 3=S, 4=Z, 5=J, 6=L; 7 is illegal.
REQ-008 rot_cw  input  1  pulse: propose a clockwise rotation.
REQ-009 rot_ccw  input  1  pulse: propose a counter-clockwise rotation.
REQ-010 accept  input  1  commit the pending rotation.
REQ-011 reject  input  1  revert the pending rotation.
REQ-012 busy  output  1  high in LOOKUP; commands are ignored while busy.
REQ-013 pending  output  1  high in PENDING.
REQ-014 out_valid  output  1  high in STABLE or PENDING.
REQ-015 rotation  output  2  current rotation index, 0..3.
REQ-016 cur_shape  output  3  latched piece code.
REQ-017 blk1_voffset..blk4_voffset  output  COORD_W each  block row offsets, zero-extended.
REQ-018 blk1_hoffset..blk4_hoffset  output  COORD_W each  block column offsets, zero-extended.

Function
REQ-019 FSM states SHALL be IDLE, LOOKUP, STABLE and PENDING, with a registered flag ret_state that selects STABLE or PENDING as the exit from LOOKUP.
REQ-020 IDLE: load with shape<=6 -> cur_shape=shape, rotation=0, ret_state=STABLE, go to LOOKUP; load with shape=7 -> no change.
REQ-021 STABLE: load has priority (same as REQ-020); otherwise exactly one of rot_cw/rot_ccw -> save rotation as prev_rot, rotation=(rotation±1) mod 4, ret_state=PENDING, go to LOOKUP.
REQ-022 STABLE: rot_cw and rot_ccw asserted together -> both ignored, no state change.
REQ-023 LOOKUP lasts exactly one cycle.
- Offsets and out_valid update on the edge leaving LOOKUP, so latency is command edge +2.
- Offsets hold their previous values during LOOKUP.
REQ-024 PENDING, load asserted -> load wins (same as REQ-020); the pending rotation is discarded.
REQ-025 PENDING, reject asserted (reject wins over accept) -> rotation=prev_rot, ret_state=STABLE, go to LOOKUP.
REQ-026 PENDING, accept only -> go to STABLE; offsets and rotation unchanged.
REQ-027 PENDING, rot_cw/rot_ccw -> ignored.
REQ-028 Rotation-0 tables, as (v,h) for blk1..blk4:
- I: (r,0)(r,1)(r,2)(r,3) with r=I_FIRST_ROW
- O: (0,0)(1,1)(0,1)(1,0)
- T: (0,1)(1,0)(1,1)(1,2)
- S: (0,1)(0,2)(1,0)(1,1)
- Z: (0,0)(0,1)(1,1)(1,2)
- J: (0,0)(1,0)(1,1)(1,2)
- L: (0,2)(1,0)(1,1)(1,2)
REQ-029 Each clockwise step SHALL map every block (v,h) -> (h, S-1-v), preserving block order; S=4 for I, S=3 for T/S/Z/J/L.
REQ-030 The O piece outputs its rotation-0 table for every rotation value; its rotation register still changes.
REQ-031 Rotation arithmetic is modulo 4: 3+1 -> 0 and 0-1 -> 3.

Reset
REQ-032 While rst or !active is sampled high:
- state=IDLE, rotation=0, prev_rot=0, cur_shape=0;
- all offsets=0;
- busy=0, pending=0, out_valid=0.
- This holds in every state, including mid-LOOKUP and PENDING.

Verification
REQ-033 rst high 2 cycles -> all outputs 0, state IDLE; with I_FIRST_ROW=1, load shape=0 -> 2 edges later offsets (1,0)(1,1)(1,2)(1,3), out_valid=1.
REQ-034 load T; rot_cw -> busy=1 for 1 cycle, then pending=1, rotation=1, offsets (1,2)(0,1)(1,1)(2,1); accept -> pending=0, offsets held.
REQ-035 load I; rot_ccw -> rotation=3, offsets (3,1)(2,1)(1,1)(0,1); reject+accept together -> rotation=0, offsets (1,0)(1,1)(1,2)(1,3), pending=0.
REQ-036 load O; rot_cw; accept -> rotation=1, offsets (0,0)(1,1)(0,1)(1,0) unchanged.
REQ-037 Boundary cases:
- rot_cw+rot_ccw together in STABLE -> no change;
- load shape=7 -> no change;
- load Z during PENDING -> rotation=0, offsets (0,0)(0,1)(1,1)(1,2), pending=0;
- active low mid-LOOKUP -> all outputs 0 next edge.
